// File: rtl/neko_mem_pkg.sv
// Shared types and constants for the neko memory-port arbiter.
package neko_mem_pkg;

  localparam int unsigned BUS_TAG_W = 7;
  localparam int unsigned REQ_TAG_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // The owner bit prefixes the tag so stale acks for the other requester never match.
  function automatic logic [BUS_TAG_W-1:0] make_bus_tag(input owner_e owner,
                                                       input logic [REQ_TAG_W-1:0] tag);
    return {owner == OWNER_B, tag};
  endfunction

endpackage

// File: rtl/neko_mem_watchdog.sv
// 16-bit busy-cycle counter; expired is high once the count equals LIMIT.
module neko_mem_watchdog #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 16'(LIMIT));

endmodule

// File: rtl/neko_mem_arbiter.sv
// Two-requester (LSU = A, fetch = B) arbiter for the single memory port,
// with tag-matched completion and a watchdog abort.
module neko_mem_arbiter
  import neko_mem_pkg::*;
#(
  parameter int unsigned MEMORY_BUS_WIDTH = 32,
  parameter int unsigned TIMEOUT          = 1023
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        a_rd_en,
  input  logic                        a_wr_en,
  input  logic [31:0]                 a_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] a_wr_data,
  input  logic [REQ_TAG_W-1:0]        a_tag,
  input  logic                        a_gm_or_lds,
  output logic                        a_ack,
  output logic                        a_err,
  output logic [MEMORY_BUS_WIDTH-1:0] a_rd_data,

  input  logic                        b_rd_en,
  input  logic                        b_wr_en,
  input  logic [31:0]                 b_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] b_wr_data,
  input  logic [REQ_TAG_W-1:0]        b_tag,
  input  logic                        b_gm_or_lds,
  output logic                        b_ack,
  output logic                        b_err,
  output logic [MEMORY_BUS_WIDTH-1:0] b_rd_data,

  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [31:0]                 mem_addr,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_wr_data,
  output logic [BUS_TAG_W-1:0]        mem_tag_req,
  output logic                        mem_gm_or_lds,
  input  logic                        mem_ack,
  input  logic [BUS_TAG_W-1:0]        mem_tag_resp,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_rd_data,

  output logic                        arb_busy,
  output logic                        timeout_sticky
);

  arb_state_e                  state_q, state_d;
  owner_e                      last_grant_q, last_grant_d;
  owner_e                      owner_q, owner_d;
  logic                        op_wr_q, op_wr_d;
  logic [31:0]                 addr_q, addr_d;
  logic [MEMORY_BUS_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                        gm_q, gm_d;
  logic [BUS_TAG_W-1:0]        tag_q, tag_d;
  logic                        err_q, err_d;
  logic [MEMORY_BUS_WIDTH-1:0] a_rd_data_q, a_rd_data_d;
  logic [MEMORY_BUS_WIDTH-1:0] b_rd_data_q, b_rd_data_d;
  logic                        sticky_q, sticky_d;

  logic a_pend, b_pend, grant_b, wd_clr, wd_expired, tag_match;
  logic [MEMORY_BUS_WIDTH-1:0] done_data;

  neko_mem_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (state_q == ST_BUSY),
    .expired(wd_expired)
  );

  assign a_pend    = a_rd_en | a_wr_en;
  assign b_pend    = b_rd_en | b_wr_en;
  assign grant_b   = b_pend && (!a_pend || (last_grant_q == OWNER_A));
  assign tag_match = mem_ack && (mem_tag_resp == tag_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    gm_d         = gm_q;
    tag_d        = tag_q;
    err_d        = err_q;
    a_rd_data_d  = a_rd_data_q;
    b_rd_data_d  = b_rd_data_q;
    sticky_d     = sticky_q;
    wd_clr       = 1'b0;
    done_data    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (a_pend || b_pend) begin
          if (grant_b) begin
            owner_d   = OWNER_B;
            op_wr_d   = b_wr_en;
            addr_d    = b_addr;
            wr_data_d = b_wr_data;
            gm_d      = b_gm_or_lds;
            tag_d     = make_bus_tag(OWNER_B, b_tag);
          end else begin
            owner_d   = OWNER_A;
            op_wr_d   = a_wr_en;
            addr_d    = a_addr;
            wr_data_d = a_wr_data;
            gm_d      = a_gm_or_lds;
            tag_d     = make_bus_tag(OWNER_A, a_tag);
          end
          last_grant_d = owner_d;
          err_d        = 1'b0;
          wd_clr       = 1'b1;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A matching ack wins over a simultaneous watchdog expiry.
        if (tag_match || wd_expired) begin
          err_d     = !tag_match;
          done_data = tag_match ? mem_rd_data : '0;
          sticky_d  = sticky_q | !tag_match;
          if (owner_q == OWNER_B) begin
            b_rd_data_d = done_data;
          end else begin
            a_rd_data_d = done_data;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWNER_B;
      owner_q      <= OWNER_A;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      gm_q         <= 1'b0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      a_rd_data_q  <= '0;
      b_rd_data_q  <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      gm_q         <= gm_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      a_rd_data_q  <= a_rd_data_d;
      b_rd_data_q  <= b_rd_data_d;
      sticky_q     <= sticky_d;
    end
  end

  assign arb_busy       = (state_q != ST_IDLE);
  assign mem_rd_en      = (state_q == ST_BUSY) && !op_wr_q;
  assign mem_wr_en      = (state_q == ST_BUSY) && op_wr_q;
  assign mem_addr       = addr_q;
  assign mem_wr_data    = wr_data_q;
  assign mem_tag_req    = tag_q;
  assign mem_gm_or_lds  = gm_q;
  assign a_ack          = (state_q == ST_RESP) && (owner_q == OWNER_A);
  assign b_ack          = (state_q == ST_RESP) && (owner_q == OWNER_B);
  assign a_err          = a_ack && err_q;
  assign b_err          = b_ack && err_q;
  assign a_rd_data      = a_rd_data_q;
  assign b_rd_data      = b_rd_data_q;
  assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_neko_mem_arbiter.sv
// Directed bench for neko_mem_arbiter: vector table of single transactions
// plus hand-written tie, stale-tag, timeout and reset sequences.
module tb_neko_mem_arbiter;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_rd_en, a_wr_en, a_gm_or_lds, a_ack, a_err;
  logic [31:0]   a_addr;
  logic [W-1:0]  a_wr_data, a_rd_data;
  logic [5:0]    a_tag;
  logic          b_rd_en, b_wr_en, b_gm_or_lds, b_ack, b_err;
  logic [31:0]   b_addr;
  logic [W-1:0]  b_wr_data, b_rd_data;
  logic [5:0]    b_tag;
  logic          mem_rd_en, mem_wr_en, mem_gm_or_lds, mem_ack;
  logic [31:0]   mem_addr;
  logic [W-1:0]  mem_wr_data, mem_rd_data;
  logic [6:0]    mem_tag_req, mem_tag_resp;
  logic          arb_busy, timeout_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neko_mem_arbiter #(
    .MEMORY_BUS_WIDTH(W),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .a_rd_en(a_rd_en), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_tag(a_tag), .a_gm_or_lds(a_gm_or_lds), .a_ack(a_ack), .a_err(a_err), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_wr_data(b_wr_data),
    .b_tag(b_tag), .b_gm_or_lds(b_gm_or_lds), .b_ack(b_ack), .b_err(b_err), .b_rd_data(b_rd_data),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_tag_req(mem_tag_req), .mem_gm_or_lds(mem_gm_or_lds), .mem_ack(mem_ack),
    .mem_tag_resp(mem_tag_resp), .mem_rd_data(mem_rd_data),
    .arb_busy(arb_busy), .timeout_sticky(timeout_sticky)
  );

  typedef struct {
    logic        is_b;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  tag;
    logic        gm;
    int          delay;
    logic [31:0] rdata;
    logic [6:0]  exp_tag;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic is_b, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [5:0] tag, input logic gm);
    if (is_b) begin
      b_rd_en = rd; b_wr_en = wr; b_addr = addr; b_wr_data = wdata; b_tag = tag; b_gm_or_lds = gm;
    end else begin
      a_rd_en = rd; a_wr_en = wr; a_addr = addr; a_wr_data = wdata; a_tag = tag; a_gm_or_lds = gm;
    end
  endtask

  task automatic clear_req(input logic is_b);
    if (is_b) begin
      b_rd_en = 1'b0; b_wr_en = 1'b0;
    end else begin
      a_rd_en = 1'b0; a_wr_en = 1'b0;
    end
  endtask

  task automatic mem_respond(input logic [6:0] tag, input logic [31:0] data);
    mem_ack = 1'b1; mem_tag_resp = tag; mem_rd_data = data;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive_req(v.is_b, v.rd, v.wr, v.addr, v.wdata, v.tag, v.gm);
    tick();
    check($sformatf("v%0d_mem_rd_en", idx), mem_rd_en, !v.exp_wr);
    check($sformatf("v%0d_mem_wr_en", idx), mem_wr_en, v.exp_wr);
    check($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    check($sformatf("v%0d_mem_wr_data", idx), mem_wr_data, v.wdata);
    check($sformatf("v%0d_mem_tag_req", idx), mem_tag_req, v.exp_tag);
    check($sformatf("v%0d_mem_gm", idx), mem_gm_or_lds, v.gm);
    for (int i = 0; i < v.delay; i++) begin
      tick();
      check($sformatf("v%0d_wait_ack", idx), {a_ack, b_ack}, 2'b00);
    end
    mem_respond(v.exp_tag, v.rdata);
    clear_req(v.is_b);
    check($sformatf("v%0d_own_ack", idx), v.is_b ? b_ack : a_ack, 1'b1);
    check($sformatf("v%0d_own_err", idx), v.is_b ? b_err : a_err, 1'b0);
    check($sformatf("v%0d_other_ack", idx), v.is_b ? a_ack : b_ack, 1'b0);
    check($sformatf("v%0d_rd_data", idx), v.is_b ? b_rd_data : a_rd_data, v.rdata);
    check($sformatf("v%0d_resp_mem_idle", idx), {mem_rd_en, mem_wr_en}, 2'b00);
    tick();
    check($sformatf("v%0d_ack_drop", idx), {a_ack, b_ack}, 2'b00);
    check($sformatf("v%0d_idle", idx), arb_busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0] = '{is_b: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h100, wdata: 32'h0, tag: 6'd5, gm: 1'b0,
                delay: 3, rdata: 32'hDEADBEEF, exp_tag: 7'h05, exp_wr: 1'b0};
    vecs[1] = '{is_b: 1'b1, rd: 1'b0, wr: 1'b1, addr: 32'h20, wdata: 32'h55, tag: 6'd3, gm: 1'b1,
                delay: 0, rdata: 32'h12345678, exp_tag: 7'h43, exp_wr: 1'b1};
    vecs[2] = '{is_b: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'hABC, wdata: 32'h0, tag: 6'h3F, gm: 1'b0,
                delay: 1, rdata: 32'hCAFEF00D, exp_tag: 7'h7F, exp_wr: 1'b0};
    vecs[3] = '{is_b: 1'b0, rd: 1'b1, wr: 1'b1, addr: 32'hFFFFFFFC, wdata: 32'hA5A5A5A5, tag: 6'h2A,
                gm: 1'b1, delay: 2, rdata: 32'h0BADF00D, exp_tag: 7'h2A, exp_wr: 1'b1};

    rst = 1'b1;
    a_rd_en = 0; a_wr_en = 0; a_addr = '0; a_wr_data = '0; a_tag = '0; a_gm_or_lds = 0;
    b_rd_en = 0; b_wr_en = 0; b_addr = '0; b_wr_data = '0; b_tag = '0; b_gm_or_lds = 0;
    mem_ack = 0; mem_tag_resp = '0; mem_rd_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_mem_en", {mem_rd_en, mem_wr_en}, 2'b00);
    check("reset_mem_bus", {mem_addr, mem_tag_req, mem_gm_or_lds}, '0);
    check("reset_acks", {a_ack, a_err, b_ack, b_err}, 4'b0);
    check("reset_rd_data", {a_rd_data, b_rd_data}, '0);
    check("reset_status", {arb_busy, timeout_sticky}, 2'b00);

    // Tie after reset: A first, B next, next tie A again.
    drive_req(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 6'h11, 1'b0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 6'h22, 1'b0);
    tick();
    check("tie1_tag", mem_tag_req, 7'h11);
    check("tie1_addr", mem_addr, 32'h1000);
    mem_respond(7'h11, 32'h1);
    clear_req(1'b0);
    check("tie1_a_ack", {a_ack, b_ack}, 2'b10);
    check("tie1_a_data", a_rd_data, 32'h1);
    tick();
    check("tie_gap_idle", {arb_busy, b_ack}, 2'b00);
    tick();
    check("tie2_tag", mem_tag_req, 7'h62);
    check("tie2_addr", mem_addr, 32'h2000);
    mem_respond(7'h62, 32'h2);
    clear_req(1'b1);
    check("tie2_b_ack", {a_ack, b_ack}, 2'b01);
    check("tie2_b_data", b_rd_data, 32'h2);
    check("tie2_a_hold", a_rd_data, 32'h1);
    tick();
    drive_req(1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 6'h01, 1'b0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 6'h02, 1'b0);
    tick();
    check("tie3_tag", mem_tag_req, 7'h01);
    mem_respond(7'h01, 32'h3);
    clear_req(1'b0);
    clear_req(1'b1);
    check("tie3_a_ack", a_ack, 1'b1);
    repeat (2) tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Stale ack for the other owner's tag must be ignored.
    drive_req(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 6'h07, 1'b0);
    tick();
    mem_respond(7'h47, 32'h111);
    check("stale_no_ack", {a_ack, b_ack}, 2'b00);
    check("stale_still_busy", {arb_busy, mem_rd_en}, 2'b11);
    mem_respond(7'h07, 32'h222);
    clear_req(1'b0);
    check("stale_then_ack", {a_ack, a_err}, 2'b10);
    check("stale_data", a_rd_data, 32'h222);
    check("sticky_before_timeout", timeout_sticky, 1'b0);
    tick();

    // Watchdog abort: ack+err 9 cycles after BUSY entry with TIMEOUT=8.
    drive_req(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 6'h09, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("to_wait%0d", i), {a_ack, arb_busy}, 2'b01);
    end
    tick();
    clear_req(1'b0);
    check("to_ack_err", {a_ack, a_err, b_ack}, 3'b110);
    check("to_rd_data_zero", a_rd_data, 32'h0);
    check("to_sticky", timeout_sticky, 1'b1);
    tick();
    check("to_ack_drop", {a_ack, a_err}, 2'b00);
    check("to_sticky_holds", timeout_sticky, 1'b1);

    // Matching ack in the expiry cycle is a normal completion.
    drive_req(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 6'h0A, 1'b0);
    tick();
    repeat (8) tick();
    check("exp_still_busy", {b_ack, arb_busy}, 2'b01);
    mem_respond(7'h4A, 32'h5EED);
    clear_req(1'b1);
    check("exp_ack_no_err", {b_ack, b_err}, 2'b10);
    check("exp_data", b_rd_data, 32'h5EED);
    tick();

    // Reset during BUSY drops the request with no ack.
    drive_req(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 6'h0C, 1'b0);
    tick();
    check("rstmid_busy", mem_rd_en, 1'b1);
    rst = 1'b1;
    tick();
    check("rstmid_mem_drop", {mem_rd_en, mem_wr_en}, 2'b00);
    check("rstmid_no_ack", {a_ack, b_ack}, 2'b00);
    check("rstmid_idle", arb_busy, 1'b0);
    check("rstmid_sticky_clr", timeout_sticky, 1'b0);
    rst = 1'b0;
    clear_req(1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neko_mem_arbiter.md
# neko_mem_arbiter

Two-requester arbiter sharing the single FPGA memory port between the LSU (requester A) and the instruction-fetch path (requester B). Each requester has at most one outstanding request. The arbiter latches the winning request, drives it onto the memory bus until a tag-matched `mem_ack` arrives, then returns a registered one-cycle acknowledge and read data to the owner. A watchdog aborts requests that never complete.

## Interface
Parameters:
- `MEMORY_BUS_WIDTH`, 32, width of the read and write data buses.
- `TIMEOUT`, 1023, cycles in BUSY without a matching ack before abort; 1..65535.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high; clock `clk`.
- `a_rd_en`, `a_wr_en` in 1 each: requester A read/write request levels, held until `a_ack`.
- `a_addr` in 32: requester A address.
- `a_wr_data` in W: requester A write data.
- `a_tag` in 6: requester A tag.
- `a_gm_or_lds` in 1: requester A space select.
- `a_ack` out 1: one-cycle completion pulse to A.
- `a_err` out 1: qualifies `a_ack` as a timeout abort.
- `a_rd_data` out W: read data to A, valid with `a_ack`.
- `b_*` ports: identical set for requester B.
- `mem_rd_en`, `mem_wr_en` out 1 each: memory request levels.
- `mem_addr` out 32: memory address.
- `mem_wr_data` out W: memory write data.
- `mem_tag_req` out 7: memory request tag.
- `mem_gm_or_lds` out 1: memory space select.
- `mem_ack` in 1: memory completion.
- `mem_tag_resp` in 7: tag returned with `mem_ack`.
- `mem_rd_data` in W: memory read data.
- `arb_busy` out 1: high whenever state is not IDLE.
- `timeout_sticky` out 1: set on any abort; cleared only by reset.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - A requester is pending when its `rd_en | wr_en` is high.
  - If none is pending, stay in IDLE.
  - If one is pending, grant it.
  - If both are pending, grant the one not named by `last_grant`. `last_grant` resets to B, so A wins the first tie.
  - On grant, latch `addr`, `wr_data`, `gm_or_lds`, `op` and `owner`, and set the tag to `{owner, tag[5:0]}` (owner A=0, B=1). Update `last_grant`, clear the watchdog, go to BUSY.
  - If `rd_en` and `wr_en` are both high, the request is issued as a write.
- **BUSY**
  - Drive `mem_rd_en` or `mem_wr_en` from the latched op; all other `mem_*` outputs come from latched registers.
  - `mem_ack` with `mem_tag_resp` equal to the latched tag: capture `mem_rd_data`, go to RESP with err=0.
  - `mem_ack` with any other tag: ignore it and stay in BUSY.
  - Watchdog increments every BUSY cycle. When it reaches `TIMEOUT` with no matching ack, go to RESP with err=1, set `timeout_sticky`, and force read data to 0.
  - A matching ack in the same cycle as watchdog expiry counts as a normal completion (err=0).
- **RESP**
  - Assert the owner's `ack` for one cycle, plus `err` if set; owner's `rd_data` holds the captured value. Write acks return captured data; requesters ignore it.
  - Next state is always IDLE.
- The non-owner's `ack`/`err` stay 0; requester data outputs hold their last values.
- Requester protocol: request fields must be stable while the request is asserted, and the request must drop in the cycle after `ack`. The IDLE cycle after RESP guarantees a completed request is never re-granted.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant`=B, watchdog 0.
- Reset mid-BUSY drops the memory request the next cycle with no ack to the owner.
- `mem_*` request outputs are registered and assert the cycle after the grant sample edge.
- Latency from a single request asserted to `mem_rd_en` high: 1 cycle.
- Requester `ack` is high exactly 1 cycle after the matching `mem_ack` cycle.
- Minimum request-to-request spacing: 4 cycles (IDLE, BUSY, RESP, IDLE) with a same-cycle `mem_ack`.
- Abort: `ack`+`err` appear `TIMEOUT`+1 cycles after BUSY entry.

## Structure
- Shared package (`neko_mem_pkg`) holds:
  - state encoding (IDLE/BUSY/RESP);
  - owner encoding (A=0, B=1);
  - tag-width constants: 7-bit bus tag, 6-bit requester tag.
- One sub-module, `neko_mem_watchdog`: 16-bit counter with clear, enable and `expired` output.

## Test plan
- A read alone at `addr`=0x100, `tag`=5; `mem_ack` 3 cycles later with tag 0x05 and data 0xDEADBEEF -> `mem_tag_req`=0x05, `a_ack` pulses once with `a_rd_data`=0xDEADBEEF, `b_ack`=0.
- A and B requesting in the same cycle after reset -> A granted first (tag 0x0X); B granted after A's RESP+IDLE (tag 0x4X); next tie goes to A again.
- B write `addr`=0x20, data 0x55 -> `mem_wr_en`=1, `mem_wr_data`=0x55, `mem_tag_req`=0x40|tag; ack -> `b_ack`=1, `b_err`=0.
- Stale `mem_ack` with the wrong tag during BUSY -> no requester ack; a later correct tag completes the request normally.
- `TIMEOUT`=8, no ack -> `a_ack`=`a_err`=1 with `a_rd_data`=0 at cycle 9, `timeout_sticky`=1; a matching ack arriving exactly at expiry -> err=0.
- `rst` asserted mid-BUSY -> `mem_rd_en`=0 on the next cycle, no ack, `arb_busy`=0.
